// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: owns the CSR file access port. In IDLE the pipeline's CSR
// instruction passes straight through; on a trap the block takes the port,
// flushes the pipeline, writes mepc/mcause and mtval, then redirects to mtvec.
// MRET is a single-cycle flush plus redirect to mepc.
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_IDLE       | pipeline owns the CSR port, trap/MRET requests sampled
// S_FLUSH      | kill IF..MEM, suppress the killed instruction's CSR access
// S_WR_EPC     | write mepc (word aligned), strobe mcause load
// S_WR_TVAL    | write mtval
// S_REDIRECT   | redirect PC to mtvec base (direct mode)
// S_MRET_REDIR | flush and redirect PC to mepc
module csr_trap_ctrl #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 13
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [CSR_AW-1:0] pipe_csr_addr_i,
    input  logic [1:0]        pipe_csr_mode_i,
    input  logic [XLEN-1:0]   pipe_csr_wdata_i,
    input  logic              exc_valid_i,
    input  logic [4:0]        exc_code_i,
    input  logic [XLEN-1:0]   exc_pc_i,
    input  logic [XLEN-1:0]   exc_tval_i,
    input  logic              mret_i,
    input  logic              csr_raise_exc_i,
    input  logic [XLEN-1:0]   csr_exc_pc_i,
    input  logic [XLEN-1:0]   mtvec_i,
    input  logic [XLEN-1:0]   mepc_i,
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic [1:0]        csr_mode_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              load_mcause_o,
    output logic [XLEN-1:0]   excep_code_o,
    output logic              flush_o,
    output logic              stall_o,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_pc_o
);

    // CSR access modes, matching proc_pkg encoding
    localparam logic [1:0] MODE_NONE = 2'd0;
    localparam logic [1:0] MODE_RW   = 2'd1;

    localparam logic [CSR_AW-1:0] ADDR_MEPC  = CSR_AW'(16'h0341);
    localparam logic [CSR_AW-1:0] ADDR_MTVAL = CSR_AW'(16'h0343);

    // Illegal-instruction cause used for CSR file access faults
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_WR_EPC,
        S_WR_TVAL,
        S_REDIRECT,
        S_MRET_REDIR
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   cause_q;
    logic [XLEN-1:0]   epc_q;
    logic [XLEN-1:0]   tval_q;

    // Sequencer: requests are only looked at in IDLE; everything else runs to completion
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (csr_raise_exc_i) begin
                        cause_q <= CAUSE_ILLEGAL;
                        epc_q   <= csr_exc_pc_i;
                        tval_q  <= '0;
                        state_q <= S_FLUSH;
                    end else if (exc_valid_i) begin
                        cause_q <= {{(XLEN-5){1'b0}}, exc_code_i};
                        epc_q   <= exc_pc_i;
                        tval_q  <= exc_tval_i;
                        state_q <= S_FLUSH;
                    end else if (mret_i) begin
                        state_q <= S_MRET_REDIR;
                    end
                end
                S_FLUSH:      state_q <= S_WR_EPC;
                S_WR_EPC:     state_q <= S_WR_TVAL;
                S_WR_TVAL:    state_q <= S_REDIRECT;
                S_REDIRECT:   state_q <= S_IDLE;
                S_MRET_REDIR: state_q <= S_IDLE;
                default:      state_q <= S_IDLE;
            endcase
        end
    end

    // Output decode from state and captured values; pass-through is gated so reset forces all-zero
    always_comb begin
        csr_addr_o       = '0;
        csr_mode_o       = MODE_NONE;
        csr_wdata_o      = '0;
        load_mcause_o    = 1'b0;
        excep_code_o     = '0;
        flush_o          = 1'b0;
        stall_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        case (state_q)
            S_IDLE: begin
                if (rst_n_i) begin
                    csr_addr_o  = pipe_csr_addr_i;
                    csr_mode_o  = pipe_csr_mode_i;
                    csr_wdata_o = pipe_csr_wdata_i;
                end
            end
            S_FLUSH: begin
                flush_o = 1'b1;
                stall_o = 1'b1;
            end
            S_WR_EPC: begin
                stall_o       = 1'b1;
                csr_addr_o    = ADDR_MEPC;
                csr_mode_o    = MODE_RW;
                csr_wdata_o   = {epc_q[XLEN-1:2], 2'b00};
                load_mcause_o = 1'b1;
                excep_code_o  = cause_q;
            end
            S_WR_TVAL: begin
                stall_o     = 1'b1;
                csr_addr_o  = ADDR_MTVAL;
                csr_mode_o  = MODE_RW;
                csr_wdata_o = tval_q;
            end
            S_REDIRECT: begin
                stall_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = {mtvec_i[XLEN-1:2], 2'b00};
            end
            S_MRET_REDIR: begin
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = mepc_i;
            end
            default: begin
                csr_mode_o = MODE_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: pass-through vector table, hand-written trap/MRET
// sequences, then randomized traffic against a queue-of-steps reference model.
module tb_csr_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [12:0] pipe_csr_addr_i;
    logic [1:0]  pipe_csr_mode_i;
    logic [31:0] pipe_csr_wdata_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic [31:0] exc_tval_i;
    logic        mret_i;
    logic        csr_raise_exc_i;
    logic [31:0] csr_exc_pc_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic [12:0] csr_addr_o;
    logic [1:0]  csr_mode_o;
    logic [31:0] csr_wdata_o;
    logic        load_mcause_o;
    logic [31:0] excep_code_o;
    logic        flush_o;
    logic        stall_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    int total = 0;
    int bad   = 0;

    csr_trap_ctrl #(.XLEN(32), .CSR_AW(13)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .pipe_csr_addr_i(pipe_csr_addr_i), .pipe_csr_mode_i(pipe_csr_mode_i),
        .pipe_csr_wdata_i(pipe_csr_wdata_i),
        .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
        .exc_tval_i(exc_tval_i), .mret_i(mret_i),
        .csr_raise_exc_i(csr_raise_exc_i), .csr_exc_pc_i(csr_exc_pc_i),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .csr_addr_o(csr_addr_o), .csr_mode_o(csr_mode_o), .csr_wdata_o(csr_wdata_o),
        .load_mcause_o(load_mcause_o), .excep_code_o(excep_code_o),
        .flush_o(flush_o), .stall_o(stall_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [12:0] addr;
        logic [1:0]  mode;
        logic [31:0] wdata;
        logic        ldm;
        logic [31:0] code;
        logic        flush;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    typedef struct {
        logic [12:0] addr;
        logic [1:0]  mode;
        logic [31:0] wdata;
        exp_t        e;
    } vec_t;

    // Reference model: one entry per upcoming non-IDLE cycle
    // kind 0=flush 1=mepc/mcause write 2=mtval write 3=redirect to mtvec 4=mret
    typedef struct {
        int          kind;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
    } step_t;

    step_t q[$];
    vec_t  vt[4];

    function automatic exp_t mk(logic [12:0] a, logic [1:0] m, logic [31:0] w, logic l,
                                logic [31:0] c, logic f, logic s, logic r, logic [31:0] p);
        exp_t e;
        e.addr = a; e.mode = m; e.wdata = w; e.ldm = l; e.code = c;
        e.flush = f; e.stall = s; e.rv = r; e.rpc = p;
        return e;
    endfunction

    function automatic exp_t idle_exp();
        return mk(pipe_csr_addr_i, pipe_csr_mode_i, pipe_csr_wdata_i, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b0, 32'h0);
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        if (q.size() == 0) return idle_exp();
        case (q[0].kind)
            0: e = mk(13'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
            1: e = mk(13'h341, 2'd1, q[0].epc & 32'hFFFF_FFFC, 1'b1, q[0].cause,
                      1'b0, 1'b1, 1'b0, 32'h0);
            2: e = mk(13'h343, 2'd1, q[0].tval, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
            3: e = mk(13'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1,
                      mtvec_i - (mtvec_i % 4));
            default: e = mk(13'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, mepc_i);
        endcase
        return e;
    endfunction

    task automatic push_trap(logic [31:0] c, logic [31:0] ep, logic [31:0] tv);
        for (int k = 0; k < 4; k++) q.push_back('{k, c, ep, tv});
    endtask

    task automatic chk(input string name, input exp_t e);
        exp_t a;
        a = mk(csr_addr_o, csr_mode_o, csr_wdata_o, load_mcause_o, excep_code_o,
               flush_o, stall_o, redirect_valid_o, redirect_pc_o);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got addr=%h mode=%0d wdata=%h ldm=%b code=%h flush=%b stall=%b rv=%b rpc=%h ; want addr=%h mode=%0d wdata=%h ldm=%b code=%h flush=%b stall=%b rv=%b rpc=%h",
                     name, a.addr, a.mode, a.wdata, a.ldm, a.code, a.flush, a.stall, a.rv, a.rpc,
                     e.addr, e.mode, e.wdata, e.ldm, e.code, e.flush, e.stall, e.rv, e.rpc);
        end
    endtask

    task automatic clear_req();
        exc_valid_i = 1'b0;
        csr_raise_exc_i = 1'b0;
        mret_i = 1'b0;
    endtask

    // Advance to the next sampling point, optionally dropping requests first
    task automatic next_chk(input string name, input bit keep, input exp_t e);
        @(negedge clk_i);
        if (!keep) clear_req();
        #1;
        chk(name, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_n_i = 1'b0;
        pipe_csr_addr_i = 13'h340; pipe_csr_mode_i = 2'd1; pipe_csr_wdata_i = 32'hDEADBEEF;
        clear_req();
        exc_code_i = 5'd0; exc_pc_i = 32'h0; exc_tval_i = 32'h0;
        csr_exc_pc_i = 32'h0; mtvec_i = 32'h0000_0203; mepc_i = 32'h0000_0480;

        // reset forces all outputs low even with pipeline traffic present
        #12;
        chk("reset_outputs", mk(13'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // IDLE pass-through vector table
        vt[0] = '{13'h340,  2'd1, 32'hDEADBEEF, mk(13'h340,  2'd1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0)};
        vt[1] = '{13'h300,  2'd2, 32'h0000_0008, mk(13'h300,  2'd2, 32'h0000_0008, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0)};
        vt[2] = '{13'h305,  2'd3, 32'hFFFF_FFFF, mk(13'h305,  2'd3, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0)};
        vt[3] = '{13'h1FFF, 2'd0, 32'h1234_5678, mk(13'h1FFF, 2'd0, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0)};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            pipe_csr_addr_i = vt[i].addr; pipe_csr_mode_i = vt[i].mode; pipe_csr_wdata_i = vt[i].wdata;
            #1;
            chk($sformatf("passthru_%0d", i), vt[i].e);
        end

        // ECALL
        @(negedge clk_i);
        pipe_csr_addr_i = 13'h340; pipe_csr_mode_i = 2'd1; pipe_csr_wdata_i = 32'hDEADBEEF;
        exc_valid_i = 1'b1; exc_code_i = 5'd11; exc_pc_i = 32'h0000_0104; exc_tval_i = 32'h0;
        mtvec_i = 32'h0000_0203;
        next_chk("ecall_flush", 0, mk(13'h0,   2'd0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0));
        next_chk("ecall_epc",   0, mk(13'h341, 2'd1, 32'h104, 1'b1, 32'd11, 1'b0, 1'b1, 1'b0, 32'h0));
        next_chk("ecall_tval",  0, mk(13'h343, 2'd1, 32'h0,   1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0));
        next_chk("ecall_redir", 0, mk(13'h0,   2'd0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h200));
        next_chk("ecall_idle",  0, mk(13'h340, 2'd1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));

        // CSR illegal access beats exc_valid; requests held through the sequence are ignored
        @(negedge clk_i);
        csr_raise_exc_i = 1'b1; csr_exc_pc_i = 32'h0000_020B;
        exc_valid_i = 1'b1; exc_code_i = 5'd4; exc_pc_i = 32'h0000_0300; exc_tval_i = 32'h55;
        mtvec_i = 32'h0000_1001;
        next_chk("ill_flush", 1, mk(13'h0,   2'd0, 32'h0,   1'b0, 32'd2, 1'b1, 1'b1, 1'b0, 32'h0) & ~{13'h0, 2'd0, 32'h0, 1'b0, 32'hFFFF_FFFF, 4'h0, 32'h0});
        next_chk("ill_epc",   1, mk(13'h341, 2'd1, 32'h208, 1'b1, 32'd2, 1'b0, 1'b1, 1'b0, 32'h0));
        next_chk("ill_tval",  1, mk(13'h343, 2'd1, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0));
        next_chk("ill_redir", 1, mk(13'h0,   2'd0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1000));
        // back-to-back: the still-present request is accepted from IDLE
        next_chk("b2b_idle",  1, mk(13'h340, 2'd1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
        next_chk("b2b_flush", 0, mk(13'h0,   2'd0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));
        next_chk("b2b_epc",   0, mk(13'h341, 2'd1, 32'h208, 1'b1, 32'd2, 1'b0, 1'b1, 1'b0, 32'h0));
        next_chk("b2b_tval",  0, mk(13'h343, 2'd1, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0));
        next_chk("b2b_redir", 0, mk(13'h0,   2'd0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1000));
        next_chk("b2b_idle2", 0, mk(13'h340, 2'd1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));

        // MRET alone
        @(negedge clk_i);
        mret_i = 1'b1; mepc_i = 32'h0000_0480;
        next_chk("mret_redir", 0, mk(13'h0,   2'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h480));
        next_chk("mret_idle",  0, mk(13'h340, 2'd1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));

        // MRET together with an exception: trap only
        @(negedge clk_i);
        mret_i = 1'b1; exc_valid_i = 1'b1; exc_code_i = 5'd3; exc_pc_i = 32'h600; exc_tval_i = 32'h600;
        mtvec_i = 32'h0000_0203;
        next_chk("mx_flush", 0, mk(13'h0,   2'd0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));
        next_chk("mx_epc",   0, mk(13'h341, 2'd1, 32'h600, 1'b1, 32'd3, 1'b0, 1'b1, 1'b0, 32'h0));
        next_chk("mx_tval",  0, mk(13'h343, 2'd1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0));
        next_chk("mx_redir", 0, mk(13'h0,   2'd0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h200));
        next_chk("mx_idle",  0, mk(13'h340, 2'd1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));

        // reset in WR_EPC aborts the sequence
        @(negedge clk_i);
        exc_valid_i = 1'b1; exc_code_i = 5'd5; exc_pc_i = 32'h700; exc_tval_i = 32'hAA;
        next_chk("rs_flush", 0, mk(13'h0,   2'd0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));
        next_chk("rs_epc",   0, mk(13'h341, 2'd1, 32'h700, 1'b1, 32'd5, 1'b0, 1'b1, 1'b0, 32'h0));
        #1;
        rst_n_i = 1'b0;
        #1;
        chk("rs_async", mk(13'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 5; i++)
            next_chk($sformatf("rs_after_%0d", i), 0,
                     mk(13'h340, 2'd1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));

        // randomized traffic against the reference model
        q.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk_i);
            pipe_csr_addr_i  = 13'($urandom);
            pipe_csr_mode_i  = 2'($urandom);
            pipe_csr_wdata_i = $urandom;
            csr_raise_exc_i  = ($urandom_range(0, 9) == 0);
            csr_exc_pc_i     = $urandom;
            exc_valid_i      = ($urandom_range(0, 3) == 0);
            exc_code_i       = 5'($urandom);
            exc_pc_i         = $urandom;
            exc_tval_i       = $urandom;
            mret_i           = ($urandom_range(0, 4) == 0);
            mtvec_i          = $urandom;
            mepc_i           = $urandom;
            #1;
            chk("rand", model_exp());
            if (q.size() != 0) void'(q.pop_front());
            else if (csr_raise_exc_i) push_trap(32'd2, csr_exc_pc_i, 32'h0);
            else if (exc_valid_i) push_trap({27'h0, exc_code_i}, exc_pc_i, exc_tval_i);
            else if (mret_i) q.push_back('{4, 32'h0, 32'h0, 32'h0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Drives the CSR block's access port: arbitrates between the pipeline's CSR instruction port and its own trap-entry writes.
- Sequences trap entry as flush, write mepc and mcause, write mtval, redirect to mtvec.
- Sequences MRET: redirect to mepc.
- Sits between the execute/memory stages and the CSR file. Consumes the CSR file's raise_exception, mtvec and mepc.

Parameters:
- XLEN, 32, data/PC width.
- CSR_AW, 13, CSR address port width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset
- pipe_csr_addr_i  in  CSR_AW  pipeline CSR address
- pipe_csr_mode_i  in  2  pipeline CSR mode (proc_pkg NONE/READ_WRITE/SET/CLR)
- pipe_csr_wdata_i  in  XLEN  pipeline CSR operand
- exc_valid_i  in  1  synchronous exception request from memory stage
- exc_code_i  in  5  cause code for exc_valid_i
- exc_pc_i  in  XLEN  PC of the faulting instruction
- exc_tval_i  in  XLEN  trap value (bad address / instruction bits)
- mret_i  in  1  MRET retiring in memory stage
- csr_raise_exc_i  in  1  CSR file illegal-access flag (registered, one cycle after access)
- csr_exc_pc_i  in  XLEN  PC of the instruction that made that access
- mtvec_i  in  XLEN  current mtvec
- mepc_i  in  XLEN  current mepc
- csr_addr_o  out  CSR_AW  to CSR file
- csr_mode_o  out  2  to CSR file
- csr_wdata_o  out  XLEN  to CSR file
- load_mcause_o  out  1  mcause load strobe
- excep_code_o  out  XLEN  mcause value
- flush_o  out  1  kill IF..MEM contents
- stall_o  out  1  freeze PC/pipeline
- redirect_valid_o  out  1  one-cycle PC redirect
- redirect_pc_o  out  XLEN  redirect target

Behaviour:
- Reset: rst_n_i is asynchronous, active-low; clock is clk_i.
  - While reset is asserted: state=IDLE and all captured registers are 0.
  - All outputs are 0; csr_mode_o=NONE.
- States are IDLE, FLUSH, WR_EPC, WR_TVAL, REDIRECT and MRET_REDIR. Outputs are decoded from the state register and the captured registers only; there is no combinational path from exc_*/mret_i to outputs.
- IDLE:
  - CSR port passes through the pipeline: csr_addr_o, csr_mode_o and csr_wdata_o equal the pipe_csr_* inputs.
  - flush_o, stall_o, load_mcause_o and redirect_valid_o are 0.
- Trap source priority, sampled in IDLE only:
  - csr_raise_exc_i is highest. It captures cause=2 (illegal instruction), epc=csr_exc_pc_i, tval=0.
  - exc_valid_i is next. It captures cause={27'b0,exc_code_i}, epc=exc_pc_i, tval=exc_tval_i.
  - Either source sends IDLE to FLUSH.
  - mret_i with no trap source active sends IDLE to MRET_REDIR.
  - A trap source and mret_i in the same cycle: the trap wins and MRET is discarded.
- FLUSH:
  - flush_o=1, stall_o=1.
  - csr_mode_o=NONE, so the killed instruction's CSR write is suppressed.
  - Next state is WR_EPC.
- WR_EPC:
  - stall_o=1. csr_addr_o=0x341, csr_mode_o=READ_WRITE, csr_wdata_o={epc[31:2],2'b00}.
  - load_mcause_o=1, excep_code_o=captured cause.
  - Next state is WR_TVAL.
- WR_TVAL:
  - stall_o=1. csr_addr_o=0x343, csr_mode_o=READ_WRITE, csr_wdata_o=tval.
  - Next state is REDIRECT.
- REDIRECT:
  - stall_o=1, redirect_valid_o=1, redirect_pc_o={mtvec_i[31:2],2'b00}. Direct mode only; mtvec[1:0] is ignored.
  - Next state is IDLE.
- MRET_REDIR:
  - flush_o=1, redirect_valid_o=1, redirect_pc_o=mepc_i. The CSR port is NONE.
  - Next state is IDLE.
- Latency: a request sampled at edge N gives flush at N+1, mepc/mcause write at N+2, mtval write at N+3 and redirect at N+4. MRET redirects at N+1.
- Requests arriving in any non-IDLE state are ignored; those instructions are flushed. This includes csr_raise_exc_i that arrives in FLUSH because of a killed access.
- Back-to-back: a request present on the cycle after REDIRECT (state=IDLE) is accepted normally.
- Asynchronous reset mid-sequence aborts immediately: no redirect is issued and no partial write is retried.
- The block does not check cause values; exc_code_i is zero-extended.

Test Plan:
- Reset, then IDLE pass-through: pipe addr=0x340, mode=READ_WRITE, wdata=0xDEADBEEF -> csr_*_o identical in the same cycle; flush_o, stall_o, redirect_valid_o, load_mcause_o all 0.
- ECALL: exc_valid_i=1, code=11, pc=0x0000_0104, tval=0, mtvec_i=0x0000_0203. Required sequence:
  - N+1: flush_o=1, csr_mode_o=NONE.
  - N+2: addr 0x341 wdata 0x104, load_mcause_o=1, excep_code_o=11.
  - N+3: addr 0x343 wdata 0.
  - N+4: redirect_valid_o=1, pc 0x200.
  - N+5: IDLE.
- CSR illegal access: csr_raise_exc_i=1 together with exc_valid_i=1 (code 4) -> cause 2 and epc=csr_exc_pc_i. A second exc_valid_i held during FLUSH..REDIRECT is ignored: exactly one redirect.
- MRET with mepc_i=0x0000_0480 -> next cycle flush_o=1, redirect_valid_o=1, pc 0x480; no CSR write. MRET plus exc_valid_i in the same cycle -> trap sequence only.
- Reset asserted in WR_EPC -> all outputs 0 immediately; after release, state is IDLE and no redirect occurs.
